rotary_decoder: RTL and testbench

Quadrature decoder and Avalon-MM register slave for the front-panel rotary encoder and its push button. Inputs are synchronised and debounced, quadrature transitions are decoded into a signed detent position, and button and step events are captured with a maskable interrupt. It sits on the Nios II data bus alongside the existing PIO peripherals. It replaces raw polling of encoder pins with a counted position and an interrupt.

---
 rtl/rotary_decoder_pkg.sv | 31 +++
 rtl/rotary_decoder_if.sv | 11 +
 rtl/rotary_decoder_debounce.sv | 34 +++
 rtl/rotary_decoder.sv | 147 ++++++++++++++
 tb/tb_rotary_decoder.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rotary_decoder_pkg.sv
// Shared constants and helpers for the front-panel rotary encoder decoder.
package rotary_pkg;

  localparam logic [1:0] ADDR_POSITION = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EVENT    = 2'd3;

  localparam int EV_CW    = 0;
  localparam int EV_CCW   = 1;
  localparam int EV_PRESS = 2;
  localparam int EV_REL   = 3;

  localparam int ST_BUTTON = 0;
  localparam int ST_DIR    = 1;
  localparam int ST_ERR    = 2;

  // Encoder phase encoded as the raw {a,b} pin pair
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

  // Gray-to-binary: position of {a,b} along the CW sequence 00,01,11,10
  function automatic logic [1:0] phase_index(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/rotary_decoder_if.sv
// Avalon-MM register port plus interrupt for the rotary decoder.
interface rotary_decoder_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, write, writedata, input readdata, irq);
  modport slave  (input address, write, writedata, output readdata, irq);
endinterface

// File: rtl/rotary_decoder_debounce.sv
// Two-flop synchroniser followed by a stability counter for one asynchronous pin.
module rotary_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [1:0]  sync;
  logic [19:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= 20'd0;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == level) begin
        cnt <= 20'd0;
      end else if (cnt == CNT_LAST) begin
        level <= sync[1];
        cnt   <= 20'd0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/rotary_decoder.sv
// Rotary encoder front end: debounced quadrature decode into a detent position,
// button/step event capture with maskable irq, Avalon-MM register slave.
//
// state | meaning
// PH_00 | last debounced {a,b} = 00
// PH_01 | last debounced {a,b} = 01
// PH_11 | last debounced {a,b} = 11
// PH_10 | last debounced {a,b} = 10
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic             clk,
  input  logic             reset,
  rotary_decoder_if.slave  bus,
  input  logic             rot_a,
  input  logic             rot_b,
  input  logic             rot_push
);

  localparam logic signed [3:0] STEPS = 4'(STEPS_PER_DETENT);

  logic deb_a, deb_b, deb_push;

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset(reset), .pin(rot_a), .level(deb_a));
  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset(reset), .pin(rot_b), .level(deb_b));
  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_push (
    .clk(clk), .reset(reset), .pin(rot_push), .level(deb_push));

  phase_t      state, state_nxt;
  logic [1:0]  cur_ab, delta;
  logic        step_fwd, step_rev, step_bad;

  assign cur_ab = {deb_a, deb_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= PH_00;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = phase_t'(cur_ab);
  end

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    delta    = phase_index(cur_ab) - phase_index(state);
    case (delta)
      2'd1:    step_fwd = 1'b1;
      2'd3:    step_rev = 1'b1;
      2'd2:    step_bad = 1'b1;
      default: ;
    endcase
  end

  logic [15:0]      pos;
  logic signed [2:0] acc;
  logic signed [3:0] acc_sum;
  logic             dir, err, push_q, irq_q;
  logic [3:0]       mask, ev, ev_set, ev_clr;
  logic [31:0]      rdata;
  logic             wr_pos, wr_st, wr_mask, wr_ev;
  logic             detent_cw, detent_ccw;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata[31:16];

  assign wr_pos  = bus.write && (bus.address == ADDR_POSITION);
  assign wr_st   = bus.write && (bus.address == ADDR_STATUS);
  assign wr_mask = bus.write && (bus.address == ADDR_MASK);
  assign wr_ev   = bus.write && (bus.address == ADDR_EVENT);

  // Accumulator is widened by one bit so +/-4 is representable before the compare
  always_comb begin
    acc_sum    = {acc[2], acc} + (step_fwd ? 4'sd1 : (step_rev ? -4'sd1 : 4'sd0));
    detent_cw  = step_fwd && (acc_sum == STEPS);
    detent_ccw = step_rev && (acc_sum == -STEPS);
    ev_set           = 4'b0000;
    ev_set[EV_CW]    = detent_cw  && !wr_pos;
    ev_set[EV_CCW]   = detent_ccw && !wr_pos;
    ev_set[EV_PRESS] = deb_push && !push_q;
    ev_set[EV_REL]   = !deb_push && push_q;
    ev_clr = wr_ev ? bus.writedata[3:0] : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos    <= 16'd0;
      acc    <= 3'sd0;
      dir    <= 1'b0;
      err    <= 1'b0;
      mask   <= 4'd0;
      ev     <= 4'd0;
      push_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_pos) begin
        pos <= bus.writedata[15:0];
        acc <= 3'sd0;
      end else if (step_bad || detent_cw || detent_ccw) begin
        acc <= 3'sd0;
        if (detent_cw) begin
          pos <= pos + 16'd1;
          dir <= 1'b1;
        end else if (detent_ccw) begin
          pos <= pos - 16'd1;
          dir <= 1'b0;
        end
      end else if (step_fwd || step_rev) begin
        acc <= acc_sum[2:0];
      end
      err    <= (err & ~(wr_st & bus.writedata[ST_ERR])) | step_bad;
      if (wr_mask) mask <= bus.writedata[3:0];
      ev     <= (ev & ~ev_clr) | ev_set;
      push_q <= deb_push;
      irq_q  <= |(ev & mask);
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (bus.address)
      ADDR_POSITION: rdata = {{16{pos[15]}}, pos};
      ADDR_STATUS: begin
        rdata[ST_BUTTON] = deb_push;
        rdata[ST_DIR]    = dir;
        rdata[ST_ERR]    = err;
      end
      ADDR_MASK:     rdata[3:0] = mask;
      default:       rdata[3:0] = ev;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= 32'd0;
    else       bus.readdata <= rdata;
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Randomised bench for rotary_decoder: reference model feeds a read scoreboard.
module tb_rotary_decoder;
  import rotary_pkg::*;

  localparam int DC   = 4;
  localparam int SPD  = 4;
  localparam int HOLD = 10;

  logic clk = 1'b0;
  logic reset;
  logic rot_a, rot_b, rot_push;

  rotary_decoder_if bus();

  rotary_decoder #(.DEBOUNCE_CYCLES(DC), .STEPS_PER_DETENT(SPD)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rot_a(rot_a), .rot_b(rot_b), .rot_push(rot_push));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    int          addr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_req = 1'b0;
  logic rd_valid = 1'b0;

  // Reference model state (integers, following the decoder's rules directly)
  logic [15:0] m_pos;
  int          m_sub;
  logic [3:0]  m_ev, m_mask;
  logic        m_err, m_dir, m_btn;
  logic [1:0]  m_ab;
  logic [1:0]  cyc [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  always @(posedge clk) rd_valid <= rd_req;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got read with empty queue, expected queued entry");
      end else begin
        e = sb.pop_front();
        check($sformatf("read_addr%0d", e.addr), bus.readdata, e.data);
        check($sformatf("irq_at_read_addr%0d", e.addr), {31'd0, bus.irq}, {31'd0, e.irq});
      end
    end
  end

  function automatic logic [31:0] model_reg(input int a);
    case (a)
      0:       return {{16{m_pos[15]}}, m_pos};
      1:       return {29'd0, m_err, m_dir, m_btn};
      2:       return {28'd0, m_mask};
      default: return {28'd0, m_ev};
    endcase
  endfunction

  function automatic int idx_of(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (cyc[i] == ab) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_pos = 16'd0; m_sub = 0; m_ev = 4'd0; m_mask = 4'd0;
    m_err = 1'b0; m_dir = 1'b0; m_btn = 1'b0; m_ab = 2'b00;
  endtask

  task automatic read_expect(input int a);
    @(negedge clk);
    bus.address = 2'(a);
    rd_req = 1'b1;
    sb.push_back('{model_reg(a), |(m_ev & m_mask), a});
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) read_expect(a);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.address = 2'(a);
    bus.writedata = d;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    case (a)
      0: begin m_pos = d[15:0]; m_sub = 0; end
      1: if (d[2]) m_err = 1'b0;
      2: m_mask = d[3:0];
      default: m_ev = m_ev & ~d[3:0];
    endcase
  endtask

  task automatic model_step(input int s);
    m_sub += s;
    if (m_sub == SPD) begin
      m_pos++; m_ev[0] = 1'b1; m_dir = 1'b1; m_sub = 0;
    end else if (m_sub == -SPD) begin
      m_pos--; m_ev[1] = 1'b1; m_dir = 1'b0; m_sub = 0;
    end
  endtask

  task automatic move(input logic [1:0] ab);
    int d;
    @(negedge clk);
    {rot_a, rot_b} = ab;
    repeat (HOLD) @(negedge clk);
    d = (idx_of(ab) - idx_of(m_ab) + 4) % 4;
    if (d == 1)      model_step(1);
    else if (d == 3) model_step(-1);
    else if (d == 2) begin m_err = 1'b1; m_sub = 0; end
    m_ab = ab;
  endtask

  task automatic cw();  move(cyc[(idx_of(m_ab) + 1) % 4]); endtask
  task automatic ccw(); move(cyc[(idx_of(m_ab) + 3) % 4]); endtask
  task automatic detent_cw();  repeat (SPD) cw();  endtask
  task automatic detent_ccw(); repeat (SPD) ccw(); endtask

  task automatic button(input logic v);
    @(negedge clk);
    rot_push = v;
    repeat (HOLD) @(negedge clk);
    if (v != m_btn) begin
      if (v) m_ev[2] = 1'b1; else m_ev[3] = 1'b1;
      m_btn = v;
    end
  endtask

  task automatic glitch(input int which, input int len);
    @(negedge clk);
    case (which)
      0:       rot_a = ~rot_a;
      1:       rot_b = ~rot_b;
      default: rot_push = ~rot_push;
    endcase
    repeat (len) @(negedge clk);
    case (which)
      0:       rot_a = ~rot_a;
      1:       rot_b = ~rot_b;
      default: rot_push = ~rot_push;
    endcase
    repeat (HOLD) @(negedge clk);
  endtask

  // Final phase change of a detent lands on the same edge as a POSITION write
  task automatic detent_with_write(input logic [15:0] val);
    logic [1:0] nxt;
    while (m_sub != SPD - 1) cw();
    nxt = cyc[(idx_of(m_ab) + 1) % 4];
    @(negedge clk);
    {rot_a, rot_b} = nxt;
    repeat (DC + 2) @(negedge clk);
    bus.address = ADDR_POSITION;
    bus.writedata = {16'd0, val};
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    repeat (HOLD) @(negedge clk);
    m_ab = nxt; m_pos = val; m_sub = 0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    reset = 1'b1;
    {rot_a, rot_b, rot_push} = 3'b000;
    bus.address = 2'd0; bus.write = 1'b0; bus.writedata = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    read_all();

    // Full CW detent, then two CCW detents
    detent_cw();
    read_all();
    detent_ccw();
    detent_ccw();
    read_all();

    // Short glitches must be filtered, a held press registers
    glitch(0, 3);
    glitch(2, 3);
    read_all();
    button(1'b1);
    read_all();
    button(1'b0);

    // Position wrap in both directions
    wr(0, 32'h0000_7FFF);
    detent_cw();
    read_expect(0);
    wr(0, 32'h0000_8000);
    detent_ccw();
    read_expect(0);

    // irq latency and masking
    wr(3, 32'hF);
    wr(2, 32'h4);
    read_expect(3);
    @(negedge clk);
    rot_push = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.irq && lat == 0) lat = i;
    end
    m_btn = 1'b1; m_ev[2] = 1'b1;
    check("irq_latency_from_press", 32'(lat), 32'(DC + 4));
    read_expect(3);
    wr(3, 32'h4);
    read_expect(3);
    button(1'b0);
    detent_cw();
    read_all();

    // Illegal jump, err clear, write colliding with detent
    move(m_ab ^ 2'b11);
    read_expect(1);
    wr(1, 32'h4);
    read_expect(1);
    wr(3, 32'hF);
    detent_with_write(16'd5);
    read_all();

    // Randomised mix
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    cw();
        2, 3:    ccw();
        4:       move(m_ab ^ 2'b11);
        5:       glitch($urandom_range(0, 2), $urandom_range(1, 3));
        6:       button(~m_btn);
        7:       wr($urandom_range(0, 3), $urandom);
        8:       wr(2, $urandom);
        default: detent_with_write(16'($urandom));
      endcase
      if (n % 5 == 4) read_all();
      else read_expect($urandom_range(0, 3));
    end

    // Reset mid-detent discards the partial accumulator
    wr(2, 32'hF);
    cw();
    cw();
    @(negedge clk);
    reset = 1'b1;
    {rot_a, rot_b, rot_push} = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    read_all();
    detent_cw();
    read_all();

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
